pattern_scanner: RTL and testbench
==================================

PATTERN_SCANNER -- requirements
Module: pattern_scanner

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of the scanned word.
REQ-002 The block SHALL have parameter PAT_W, default 4, giving the pattern width; legal range 1 <= PAT_W <= DATA_W.
REQ-003 The block SHALL have parameter SUM_W, default 8, giving the index-sum accumulator width.
REQ-004 The block SHALL use N = DATA_W-PAT_W+1 (window count) and CNT_W = clog2(N+1).
REQ-005 Port clock, input, 1, the single clock; all state changes on the rising edge.
REQ-006 Port reset, input, 1, asynchronous active-low reset.
REQ-007 Port cypher, input, DATA_W, word to scan; sampled only on an accepted start.
REQ-008 Port compared, input, PAT_W, pattern to find; sampled only on an accepted start.
REQ-009 Port read, input, 1, start request.
REQ-010 Port busy, output, 1, high while a scan is in progress (state not IDLE).
REQ-011 Port done, output, 1, one-cycle completion pulse.
REQ-012 Port match, output, 1, high if the last completed scan found at least one window.
REQ-013 Port count, output, CNT_W, number of matching windows in the last completed scan.
REQ-014 Port sum, output, SUM_W, sum of the bit indices of matching windows in the last completed scan.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-016 In IDLE with read=1 at edge k, the block SHALL latch cypher and compared, clear index, accumulators and count, and enter SCAN.
REQ-017 read SHALL be ignored in SCAN and DONE; the latched operands SHALL NOT change mid-scan.
REQ-018 At edges k+1 .. k+N, window i = latched cypher[i+PAT_W-1:i] SHALL be compared against latched compared, with i = 0 .. N-1 in ascending order.
REQ-019 On a window equality, the block SHALL add i to the sum accumulator and increment the count accumulator in the same edge.
REQ-020 At edge k+N, the block SHALL enter DONE and load sum, count, and match (count != 0) from the final accumulator values, including window N-1.
REQ-021 done SHALL be 1 only in DONE, i.e. exactly one cycle, N cycles after the start was sampled; DONE SHALL then go to IDLE unconditionally.
REQ-022 sum, count, and match SHALL hold their values until the next DONE entry or reset.
REQ-023 Windows SHALL overlap; every matching position counts independently.
REQ-024 For PAT_W = DATA_W, N = 1 and the scan SHALL take one SCAN cycle.
REQ-025 When the sum exceeds 2^SUM_W-1, overflow behaviour SHALL follow REQ-030.
REQ-026 count SHALL never overflow, by construction of CNT_W.

Reset
REQ-027 reset low SHALL immediately force state IDLE, busy=0, done=0, match=0, count=0, sum=0, and clear the index, accumulators, and operand registers, regardless of state.
REQ-028 A reset asserted mid-scan SHALL abort the scan with no done pulse; after release, the first read in IDLE starts a fresh scan.
REQ-029 Reset release SHALL be treated as synchronous to clock; the first edge after release may accept read.

Configuration
REQ-030 The macro PATTERN_SCANNER_SATURATE_EN SHALL control sum overflow:
- Defined: the accumulator SHALL clamp at 2^SUM_W-1 and hold there.
- Undefined: it SHALL wrap modulo 2^SUM_W.
- count and match are unaffected either way.

Verification
REQ-031 Defaults, cypher=16'hAAAA, compared=4'hA, read pulse -> done exactly 13 cycles later; match=1, count=7, sum=42.
REQ-032 Defaults, cypher=16'h0000, compared=4'hF -> match=0, count=0, sum=0, done pulse one cycle wide.
REQ-033 Defaults, cypher=16'hF000, compared=4'hF -> match=1, count=1, sum=12 (top window included); read held high during busy -> no second scan starts before IDLE.
REQ-034 DATA_W=32, PAT_W=1, SUM_W=8, cypher=all ones, compared=1 -> count=32; sum=240 without PATTERN_SCANNER_SATURATE_EN, sum=255 with it.
REQ-035 Defaults, reset pulled low 5 cycles into a scan of 16'hAAAA -> all outputs 0 asynchronously, no done pulse; new read with 16'hF000/4'hF -> sum=12, count=1.

Source files
------------

// File: rtl/pattern_scanner.sv
// Serial pattern scanner: walks every PAT_W-bit window of a latched word, counting matches and summing their bit indices.
// Optional macro PATTERN_SCANNER_SATURATE_EN clamps the index sum at its maximum instead of wrapping.
module pattern_scanner #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 4,
  parameter int SUM_W  = 8,
  localparam int N     = DATA_W - PAT_W + 1,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] cypher,
  input  logic [PAT_W-1:0]  compared,
  input  logic              read,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [CNT_W-1:0]  count,
  output logic [SUM_W-1:0]  sum,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  cyph_q, cyph_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [SUM_W-1:0]   sum_acc_q, sum_acc_d;
  logic [CNT_W-1:0]   cnt_acc_q, cnt_acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SUM_W-1:0]   sum_q, sum_d;

  logic [PAT_W-1:0]   win;
  logic               hit;
  logic               last_win;
  logic [SUM_W-1:0]   sum_next;
  logic [CNT_W-1:0]   cnt_next;

`ifdef PATTERN_SCANNER_SATURATE_EN
  localparam int ADD_W = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;
  localparam logic [ADD_W-1:0] SUM_MAX = {{(ADD_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};
  logic [ADD_W-1:0]   sum_wide;
`endif

  // Current window and the accumulator values it would produce.
  always_comb begin
    win      = PAT_W'(cyph_q >> idx_q);
    hit      = (win == pat_q);
    last_win = (idx_q == CNT_W'(N - 1));
    cnt_next = cnt_acc_q + CNT_W'(hit);
`ifdef PATTERN_SCANNER_SATURATE_EN
    sum_wide = ADD_W'(sum_acc_q) + ADD_W'(idx_q);
    if (!hit)                 sum_next = sum_acc_q;
    else if (sum_wide > SUM_MAX) sum_next = '1;
    else                      sum_next = sum_wide[SUM_W-1:0];
`else
    sum_next = hit ? (sum_acc_q + SUM_W'(idx_q)) : sum_acc_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cyph_d    = cyph_q;
    pat_d     = pat_q;
    idx_d     = idx_q;
    sum_acc_d = sum_acc_q;
    cnt_acc_d = cnt_acc_q;
    match_d   = match_q;
    count_d   = count_q;
    sum_d     = sum_q;

    case (state_q)
      IDLE: begin
        if (read) begin
          cyph_d    = cypher;
          pat_d     = compared;
          idx_d     = '0;
          sum_acc_d = '0;
          cnt_acc_d = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        sum_acc_d = sum_next;
        cnt_acc_d = cnt_next;
        if (last_win) begin
          // Results include the final window, so load from the next-values.
          idx_d   = '0;
          sum_d   = sum_next;
          count_d = cnt_next;
          match_d = (cnt_next != '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cyph_q    <= '0;
      pat_q     <= '0;
      idx_q     <= '0;
      sum_acc_q <= '0;
      cnt_acc_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      count_q   <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyph_q    <= cyph_d;
      pat_q     <= pat_d;
      idx_q     <= idx_d;
      sum_acc_q <= sum_acc_d;
      cnt_acc_q <= cnt_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      match_q   <= match_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign match     = match_q;
  assign count     = count_q;
  assign sum       = sum_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pattern_scanner.sv
// Directed bench for pattern_scanner: default instance plus a 32-bit / 1-bit-pattern instance.
module tb_pattern_scanner;

  logic        clock;
  logic        reset;

  logic [15:0] cypher;
  logic [3:0]  compared;
  logic        read;
  logic        busy, done, match;
  logic [3:0]  count;
  logic [7:0]  sum;
  logic [1:0]  dbg_state;

  logic [31:0] w_cypher;
  logic [0:0]  w_compared;
  logic        w_read;
  logic        w_busy, w_done, w_match;
  logic [5:0]  w_count;
  logic [7:0]  w_sum;
  logic [1:0]  w_dbg_state;

  int checks;
  int failures;

  pattern_scanner u_dut (
    .clock(clock), .reset(reset), .cypher(cypher), .compared(compared), .read(read),
    .busy(busy), .done(done), .match(match), .count(count), .sum(sum), .dbg_state(dbg_state)
  );

  pattern_scanner #(.DATA_W(32), .PAT_W(1), .SUM_W(8)) u_wide (
    .clock(clock), .reset(reset), .cypher(w_cypher), .compared(w_compared), .read(w_read),
    .busy(w_busy), .done(w_done), .match(w_match), .count(w_count), .sum(w_sum),
    .dbg_state(w_dbg_state)
  );

  // Clock and reset.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a scan on the default instance and wait for done; operand inputs are
  // scrambled after the start edge so results prove the operands were latched.
  task automatic run_scan(input logic [15:0] cyp, input logic [3:0] pat, input bit hold,
                          output int lat);
    @(negedge clock);
    cypher   = cyp;
    compared = pat;
    read     = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) read = 1'b0;
    cypher   = ~cyp;
    compared = ~pat;
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input logic m,
                               input logic [3:0] c, input logic [7:0] s);
    check({tag, "_latency"}, lat, 13);
    check({tag, "_match"}, match, m);
    check({tag, "_count"}, count, c);
    check({tag, "_sum"}, sum, s);
    @(posedge clock);
    #1;
    check({tag, "_done_width"}, done, 0);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int lat;
    bit saw_done;
    logic [7:0] w_exp_sum;
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    read       = 1'b0;
    cypher     = '0;
    compared   = '0;
    w_read     = 1'b0;
    w_cypher   = '0;
    w_compared = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    check("rst_count", count, 0);
    check("rst_sum", sum, 0);
    check("rst_w_busy", w_busy, 0);
    check("rst_w_count", w_count, 0);
    @(negedge clock);
    reset = 1'b1;

    // Alternating bits: every even window matches, 0+2+..+12.
    run_scan(16'hAAAA, 4'hA, 0, lat);
    expect_result("aaaa", lat, 1'b1, 4'd7, 8'd42);

    run_scan(16'h0000, 4'hF, 0, lat);
    expect_result("zero", lat, 1'b0, 4'd0, 8'd0);

    // Top window only; read held high through the scan.
    run_scan(16'hF000, 4'hF, 1, lat);
    check("f000_latency", lat, 13);
    check("f000_match", match, 1);
    check("f000_count", count, 1);
    check("f000_sum", sum, 12);
    @(posedge clock);
    #1;
    check("hold_done_width", done, 0);
    check("hold_idle_busy", busy, 0);
    read = 1'b0;
    @(posedge clock);
    #1;
    check("hold_no_restart", busy, 0);

    run_scan(16'h0F0F, 4'hF, 0, lat);
    expect_result("0f0f", lat, 1'b1, 4'd2, 8'd8);

    // Every window matches: 13 windows, 0+1+..+12.
    run_scan(16'h0000, 4'h0, 0, lat);
    expect_result("all", lat, 1'b1, 4'd13, 8'd78);

    // Reset mid-scan.
    @(negedge clock);
    cypher   = 16'hAAAA;
    compared = 4'hA;
    read     = 1'b1;
    @(posedge clock);
    #1;
    read = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid_hold_count", count, 13);
    check("mid_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_match", match, 0);
    check("arst_count", count, 0);
    check("arst_sum", sum, 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("arst_no_done", saw_done, 0);
    @(negedge clock);
    reset = 1'b1;
    run_scan(16'hF000, 4'hF, 0, lat);
    expect_result("post_rst", lat, 1'b1, 4'd1, 8'd12);

    // Wide instance: 32 single-bit windows all match, index sum 496.
`ifdef PATTERN_SCANNER_SATURATE_EN
    w_exp_sum = 8'd255;
`else
    w_exp_sum = 8'd240;
`endif
    @(negedge clock);
    w_cypher   = 32'hFFFF_FFFF;
    w_compared = 1'b1;
    w_read     = 1'b1;
    @(posedge clock);
    #1;
    w_read   = 1'b0;
    w_cypher = '0;
    lat = 0;
    while (!w_done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("wide_latency", lat, 32);
    check("wide_match", w_match, 1);
    check("wide_count", w_count, 32);
    check("wide_sum", w_sum, w_exp_sum);
    @(posedge clock);
    #1;
    check("wide_done_width", w_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
